// File: rtl/usart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usart_pkg
//  Description : Shared types and constants for the USART transmit serializer.
//                Holds the serializer state encoding and the fixed line levels
//                of the frame (idle, start and stop).
//                Optional feature macro: USART_TX_PARITY_EN (adds PARITY state).
//  Revision    : 1.0 - initial release
// ============================================================================
package usart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic TX_IDLE   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Encodings are fixed so the PARITY slot stays reserved whether or not
   // the parity build is selected.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef USART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

endpackage : usart_pkg
`default_nettype wire

// File: rtl/usart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : usart_baud_tick
//  Description : Clocks-per-bit counter. Counts 0..CLKS_PER_BIT-1 and raises
//                tick on the last cycle of every bit period.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                clr_cnt - restart the count at 0 on the next edge
//                tick    - high during the final cycle of a bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module usart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_cnt,
   output logic tick
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
         $error("usart_baud_tick: CLKS_PER_BIT must be within 2..65535");
      end
   endgenerate

   logic [CNT_W-1:0] cnt;

   // The wrap at CNT_LAST keeps the count inside 0..CLKS_PER_BIT-1 even when
   // CLKS_PER_BIT is not a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr_cnt || (cnt == CNT_LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule : usart_baud_tick
`default_nettype wire

// File: rtl/usart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : usart_tx_serializer
//  Description : Byte-to-serial transmitter. Accepts one byte per valid/ready
//                handshake and emits an idle-high frame: start bit, 8 data
//                bits LSB first, optional even parity, STOP_BITS stop bits.
//                Optional feature macro: USART_TX_PARITY_EN.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                data_in - byte to send, sampled on the handshake edge
//                valid   - producer has data_in available
//                ready   - block accepts a byte this cycle
//                tx      - serial line, idle high
//                busy    - frame in progress
//                done    - one-cycle pulse on the last cycle of the last stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module usart_tx_serializer
   import usart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   generate
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("usart_tx_serializer: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_t            state;
   tx_state_t            next_state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic [2:0]           bit_cnt;
   logic [2:0]           bit_cnt_next;
   logic                 tx_next;
   logic                 ready_next;
   logic                 busy_next;
   logic                 done_next;
   logic                 handshake;
   logic                 tick;

   usart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_cnt (handshake),
      .tick    (tick)
   );

`ifdef USART_TX_PARITY_EN
   // The shift register is consumed during DATA, so the parity of the
   // accepted byte is captured once at the handshake.
   logic parity_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_bit <= 1'b0;
      end else if (handshake) begin
         parity_bit <= ^data_in;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      tx_next      = TX_IDLE;
      done_next    = 1'b0;
      handshake    = 1'b0;

      case (state)
         IDLE: begin
            if (valid && ready) begin
               handshake  = 1'b1;
               shift_next = data_in;
               next_state = START;
            end
         end
         START: begin
            tx_next = START_BIT;
            if (tick) begin
               next_state = DATA;
            end
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (tick) begin
               shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
               // Rolls over from 7 back to 0, leaving it cleared for STOP.
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == BIT_LAST) begin
`ifdef USART_TX_PARITY_EN
                  next_state = PARITY;
`else
                  next_state = STOP;
`endif
               end
            end
         end
`ifdef USART_TX_PARITY_EN
         PARITY: begin
            tx_next = parity_bit;
            if (tick) begin
               next_state = STOP;
            end
         end
`endif
         STOP: begin
            tx_next = STOP_BIT;
            // bit_cnt is reused to count stop bits.
            if (tick) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_cnt_next = 3'd0;
                  done_next    = 1'b1;
                  next_state   = IDLE;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      // ready must drop on the handshake edge itself, yet must not rise
      // until the cycle after done, hence both current and next state idle.
      ready_next = (state == IDLE) && !handshake;
      busy_next  = !ready_next;
   end

   // tx follows the state of the previous cycle, so the line falls on the
   // first edge after the handshake and each bit lasts CLKS_PER_BIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_cnt   <= 3'd0;
         tx        <= TX_IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
         tx        <= tx_next;
         ready     <= ready_next;
         busy      <= busy_next;
         done      <= done_next;
      end
   end

endmodule : usart_tx_serializer
`default_nettype wire

// File: tb/tb_usart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usart_tx_serializer
//  Description : Directed self-checking bench for usart_tx_serializer with
//                CLKS_PER_BIT=4; one instance with one stop bit and one with
//                two. Parity expectations follow USART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usart_tx_serializer;

   localparam int CPB = 4;
`ifdef USART_TX_PARITY_EN
   localparam int PAR = 1;
   // Hand-derived bit sequences, index 0 = start bit.
   localparam logic [15:0] EXP_A5   = 16'h054A;
   localparam logic [15:0] EXP_07   = 16'h060E;
   localparam logic [15:0] EXP_00   = 16'h0400;
   localparam logic [15:0] EXP_FF   = 16'h05FE;
   localparam logic [15:0] EXP_3C   = 16'h0478;
   localparam logic [15:0] EXP_01S2 = 16'h0E02;
`else
   localparam int PAR = 0;
   localparam logic [15:0] EXP_A5   = 16'h034A;
   localparam logic [15:0] EXP_07   = 16'h020E;
   localparam logic [15:0] EXP_00   = 16'h0200;
   localparam logic [15:0] EXP_FF   = 16'h03FE;
   localparam logic [15:0] EXP_3C   = 16'h0278;
   localparam logic [15:0] EXP_01S2 = 16'h0602;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data1, data2;
   logic       valid1, valid2;
   logic       ready1, ready2;
   logic       tx1, tx2;
   logic       busy1, busy2;
   logic       done1, done2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   usart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data1), .valid(valid1),
      .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
   );

   usart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .data_in(data2), .valid(valid2),
      .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PAR == 1 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic drive(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         valid2 = v; data2 = d;
      end else begin
         valid1 = v; data1 = d;
      end
   endtask

   // mode 0: drop valid after the handshake
   // mode 1: keep valid high with next_b (back-to-back)
   // mode 2: keep valid high, change data every cycle, drop valid after the frame
   task automatic send_frame(input bit sel, input logic [7:0] b, input int mode,
                             input logic [7:0] next_b, output logic [15:0] cap);
      int   sb;
      int   fl;
      int   waitc;
      logic t, r, bz, dn;
      sb    = sel ? 2 : 1;
      fl    = (9 + sb + PAR) * CPB;
      cap   = '0;
      waitc = 0;
      while ((sel ? ready2 : ready1) !== 1'b1 && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if ((sel ? ready2 : ready1) !== 1'b1) begin
         check("ready_wait", 32'd0, 32'd1);
         return;
      end
      drive(sel, 1'b1, b);
      @(posedge clk);
      @(negedge clk);
      t = sel ? tx2 : tx1; r = sel ? ready2 : ready1; bz = sel ? busy2 : busy1;
      check($sformatf("c0_tx_%02h", b), 32'(t), 32'd1);
      check($sformatf("c0_ready_%02h", b), 32'(r), 32'd0);
      check($sformatf("c0_busy_%02h", b), 32'(bz), 32'd1);
      if (mode == 0) drive(sel, 1'b0, 8'h00);
      else if (mode == 1) drive(sel, 1'b1, next_b);
      else drive(sel, 1'b1, 8'($urandom));
      for (int k = 1; k <= fl; k++) begin
         @(negedge clk);
         t  = sel ? tx2 : tx1;
         r  = sel ? ready2 : ready1;
         bz = sel ? busy2 : busy1;
         dn = sel ? done2 : done1;
         check($sformatf("tx_%02h_c%0d", b, k), 32'(t), 32'(exp_bit(b, (k-1)/CPB)));
         check($sformatf("done_%02h_c%0d", b, k), 32'(dn), (k == fl) ? 32'd1 : 32'd0);
         check($sformatf("ready_%02h_c%0d", b, k), 32'(r), 32'd0);
         check($sformatf("busy_%02h_c%0d", b, k), 32'(bz), 32'd1);
         if (((k-1) % CPB) == CPB/2) cap[(k-1)/CPB] = t;
         if (mode == 2) drive(sel, 1'b1, 8'($urandom));
      end
      @(negedge clk);
      t = sel ? tx2 : tx1; r = sel ? ready2 : ready1;
      bz = sel ? busy2 : busy1; dn = sel ? done2 : done1;
      check($sformatf("end_ready_%02h", b), 32'(r), 32'd1);
      check($sformatf("end_busy_%02h", b), 32'(bz), 32'd0);
      check($sformatf("end_done_%02h", b), 32'(dn), 32'd0);
      check($sformatf("end_tx_%02h", b), 32'(t), 32'd1);
      if (mode == 2) drive(sel, 1'b0, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cap;
      int          done_seen;
      int          tx_low_seen;
      rst_n = 1'b0;
      valid1 = 1'b0; data1 = 8'h00;
      valid2 = 1'b0; data2 = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx1), 32'd1);
      check("rst_ready", 32'(ready1), 32'd1);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx", 32'(tx1), 32'd1);
      check("idle_ready", 32'(ready1), 32'd1);
      check("idle_busy", 32'(busy1), 32'd0);
      check("idle_done", 32'(done1), 32'd0);

      send_frame(1'b0, 8'hA5, 0, 8'h00, cap);
      check("bits_a5", 32'(cap), 32'(EXP_A5));
      send_frame(1'b0, 8'h07, 0, 8'h00, cap);
      check("bits_07", 32'(cap), 32'(EXP_07));

      // Back-to-back: valid stays high across both frames.
      send_frame(1'b0, 8'h00, 1, 8'hFF, cap);
      check("bits_00", 32'(cap), 32'(EXP_00));
      send_frame(1'b0, 8'hFF, 0, 8'h00, cap);
      check("bits_ff", 32'(cap), 32'(EXP_FF));

      // Data changes every cycle after the handshake.
      send_frame(1'b0, 8'h3C, 2, 8'h00, cap);
      check("bits_3c", 32'(cap), 32'(EXP_3C));

      // Two stop bits.
      send_frame(1'b1, 8'h01, 0, 8'h00, cap);
      check("bits_01_stop2", 32'(cap), 32'(EXP_01S2));

      // Reset in the middle of a frame.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h00);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00);
      repeat (10) @(negedge clk);
      check("pre_abort_tx", 32'(tx1), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_tx_async", 32'(tx1), 32'd1);
      check("abort_ready", 32'(ready1), 32'd1);
      check("abort_busy", 32'(busy1), 32'd0);
      check("abort_done", 32'(done1), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen   = 0;
      tx_low_seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done1 !== 1'b0) done_seen++;
         if (tx1 !== 1'b1) tx_low_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_tx_idle", 32'(tx_low_seen), 32'd0);
      check("abort_ready_after", 32'(ready1), 32'd1);

      // The block accepts a fresh byte after the aborted frame.
      send_frame(1'b0, 8'hA5, 0, 8'h00, cap);
      check("bits_a5_after_abort", 32'(cap), 32'(EXP_A5));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_usart_tx_serializer
`default_nettype wire
